// File: rtl/decode_sched_pkg.sv
// Shared definitions for the decode scheduler: FSM state encoding and default sizing.
package decode_sched_pkg;

    localparam int DEFAULT_NREQ = 4;
    localparam int DEFAULT_SELW = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DECODE = 2'd1,
        HOLD   = 2'd2
    } sched_state_t;

endpackage

// File: rtl/sel_decoder.sv
// Registered active-low one-hot decoder; the result rests at all ones when nothing is loaded.
module sel_decoder
    import decode_sched_pkg::*;
#(
    parameter int SELW = DEFAULT_SELW
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic                 clear,
    input  logic [SELW-1:0]      sel,
    output logic [(1<<SELW)-1:0] out_data
);

    localparam int OUTW = 1 << SELW;

    always_ff @(negedge clk) begin
        if (rst || clear) begin
            out_data <= '1;
        end else if (load) begin
            out_data <= ~(OUTW'(1) << sel);
        end
    end

endmodule

// File: rtl/decode_scheduler.sv
// Round-robin scheduler: grants one requester at a time, decodes its select into an
// active-low one-hot result and holds it until the consumer accepts it.
module decode_scheduler
    import decode_sched_pkg::*;
#(
    parameter int NREQ = DEFAULT_NREQ,
    parameter int SELW = DEFAULT_SELW
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*SELW-1:0]    sel,
    output logic [NREQ-1:0]         gnt,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [(1<<SELW)-1:0]    out_data,
    output logic [$clog2(NREQ)-1:0] out_id,
    output logic                    busy,
    output logic [7:0]              txn_cnt
);

    localparam int IDW = $clog2(NREQ);

    sched_state_t    state;
    sched_state_t    next_state;
    logic [IDW-1:0]  rr_ptr;
    logic [IDW-1:0]  cand;
    logic [IDW-1:0]  grant_idx;
    logic            grant_found;
    logic            accept;
    logic            complete;
    logic [SELW-1:0] win_sel;

    // Cyclic priority search starting at rr_ptr; the index wraps naturally since NREQ is a power of 2.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = rr_ptr + IDW'(k);
            if (!grant_found && req[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    assign win_sel = sel[grant_idx*SELW +: SELW];

    always_ff @(negedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Grant is combinational in IDLE so it is already low once the FSM leaves IDLE.
    always_comb begin
        next_state = state;
        gnt        = '0;
        accept     = 1'b0;
        complete   = 1'b0;
        case (state)
            IDLE: begin
                if (grant_found) begin
                    gnt[grant_idx] = 1'b1;
                    accept         = 1'b1;
                    next_state     = DECODE;
                end
            end
            DECODE: begin
                next_state = HOLD;
            end
            HOLD: begin
                if (out_valid && out_ready) begin
                    complete   = 1'b1;
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
        if (rst) begin
            gnt      = '0;
            accept   = 1'b0;
            complete = 1'b0;
        end
    end

    always_ff @(negedge clk) begin
        if (rst) begin
            rr_ptr    <= '0;
            out_id    <= '0;
            out_valid <= 1'b0;
            txn_cnt   <= 8'd0;
        end else begin
            if (accept) begin
                out_id    <= grant_idx;
                out_valid <= 1'b1;
            end
            if (complete) begin
                out_valid <= 1'b0;
                rr_ptr    <= out_id + 1'b1;
                if (txn_cnt != 8'hFF) begin
                    txn_cnt <= txn_cnt + 8'd1;
                end
            end
        end
    end

    sel_decoder #(
        .SELW(SELW)
    ) u_sel_decoder (
        .clk     (clk),
        .rst     (rst),
        .load    (accept),
        .clear   (complete),
        .sel     (win_sel),
        .out_data(out_data)
    );

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_decode_scheduler.sv
// Directed self-checking bench for decode_scheduler; inputs change and outputs are
// sampled just after the rising edge, well away from the falling edge the DUT uses.
module tb_decode_scheduler;
    import decode_sched_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [11:0] sel;
    logic [3:0]  gnt;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic [1:0]  out_id;
    logic        busy;
    logic [7:0]  txn_cnt;

    int          compare_count  = 0;
    int          mismatch_count = 0;
    logic [3:0]  exp_gnt;
    logic [7:0]  exp_data;

    always #5 clk = ~clk;

    decode_scheduler #(
        .NREQ(4),
        .SELW(3)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .sel      (sel),
        .gnt      (gnt),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_id   (out_id),
        .busy     (busy),
        .txn_cnt  (txn_cnt)
    );

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic r, input logic [3:0] rq,
                                 input logic [11:0] s, input logic rdy);
        rst       = r;
        req       = rq;
        sel       = s;
        out_ready = rdy;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        compare_count++;
        if (actual !== expected) begin
            mismatch_count++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    task automatic doReset();
        applyStimulus(1'b1, 4'b0000, 12'h000, 1'b0);
        stepCycle();
        stepCycle();
    endtask

    initial begin
        // Reset with requests pending: nothing may be granted.
        applyStimulus(1'b1, 4'b1111, 12'h000, 1'b1);
        stepCycle();
        stepCycle();
        checkOutput("rst_gnt", gnt, 4'b0000);
        checkOutput("rst_valid", out_valid, 1'b0);
        checkOutput("rst_data", out_data, 8'hFF);
        checkOutput("rst_id", out_id, 2'd0);
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_txn", txn_cnt, 8'd0);

        // Single transaction, requester 0 selecting 2.
        applyStimulus(1'b0, 4'b0001, 12'h002, 1'b1);
        checkOutput("single_gnt", gnt, 4'b0001);
        stepCycle();
        checkOutput("single_gnt_off", gnt, 4'b0000);
        checkOutput("single_valid", out_valid, 1'b1);
        checkOutput("single_data", out_data, 8'hFB);
        checkOutput("single_id", out_id, 2'd0);
        checkOutput("single_busy", busy, 1'b1);
        applyStimulus(1'b0, 4'b0000, 12'h002, 1'b1);
        stepCycle();
        checkOutput("single_hold_valid", out_valid, 1'b1);
        stepCycle();
        checkOutput("single_txn", txn_cnt, 8'd1);
        checkOutput("single_done_valid", out_valid, 1'b0);
        checkOutput("single_done_data", out_data, 8'hFF);
        checkOutput("single_done_busy", busy, 1'b0);

        // All requesting, requester i selects i: grants every third cycle in order 0,1,2,3,0.
        doReset();
        applyStimulus(1'b0, 4'b1111, 12'b011_010_001_000, 1'b1);
        for (int w = 0; w <= 12; w++) begin
            exp_gnt  = (w % 3 == 0) ? 4'(1 << ((w / 3) % 4)) : 4'b0000;
            exp_data = (w % 3 == 0) ? 8'hFF : ~8'(1 << ((w / 3) % 4));
            checkOutput($sformatf("rr_gnt_w%0d", w), gnt, exp_gnt);
            checkOutput($sformatf("rr_data_w%0d", w), out_data, exp_data);
            stepCycle();
        end

        // Backpressure while holding select 7; a select change after the grant must not leak in.
        doReset();
        applyStimulus(1'b0, 4'b0001, 12'h007, 1'b0);
        checkOutput("bp_gnt", gnt, 4'b0001);
        stepCycle();
        applyStimulus(1'b0, 4'b0001, 12'h000, 1'b0);
        checkOutput("bp_decode_data", out_data, 8'h7F);
        for (int k = 0; k < 5; k++) begin
            stepCycle();
            checkOutput($sformatf("bp_data_%0d", k), out_data, 8'h7F);
            checkOutput($sformatf("bp_busy_%0d", k), busy, 1'b1);
            checkOutput($sformatf("bp_gnt_%0d", k), gnt, 4'b0000);
            checkOutput($sformatf("bp_valid_%0d", k), out_valid, 1'b1);
        end
        applyStimulus(1'b0, 4'b0000, 12'h000, 1'b1);
        stepCycle();
        checkOutput("bp_done_valid", out_valid, 1'b0);
        checkOutput("bp_done_busy", busy, 1'b0);
        checkOutput("bp_done_txn", txn_cnt, 8'd1);
        checkOutput("bp_done_gnt", gnt, 4'b0000);
        checkOutput("bp_done_data", out_data, 8'hFF);

        // Pointer wrap: after serving 2 the search starts at 3, then wraps to 0.
        doReset();
        applyStimulus(1'b0, 4'b0100, 12'h000, 1'b1);
        checkOutput("wrap_gnt2", gnt, 4'b0100);
        stepCycle();
        stepCycle();
        stepCycle();
        applyStimulus(1'b0, 4'b1001, 12'h000, 1'b1);
        checkOutput("wrap_gnt3", gnt, 4'b1000);
        stepCycle();
        checkOutput("wrap_id3", out_id, 2'd3);
        stepCycle();
        stepCycle();
        checkOutput("wrap_gnt0", gnt, 4'b0001);
        applyStimulus(1'b0, 4'b1001, 12'h000, 1'b0);
        stepCycle();
        checkOutput("wrap_id0", out_id, 2'd0);
        stepCycle();
        checkOutput("wrap_hold_valid", out_valid, 1'b1);
        checkOutput("wrap_hold_txn", txn_cnt, 8'd2);

        // Reset while holding a result, with ready high: the transfer must not count.
        applyStimulus(1'b1, 4'b1001, 12'h000, 1'b1);
        stepCycle();
        checkOutput("midrst_valid", out_valid, 1'b0);
        checkOutput("midrst_data", out_data, 8'hFF);
        checkOutput("midrst_txn", txn_cnt, 8'd0);
        checkOutput("midrst_busy", busy, 1'b0);
        checkOutput("midrst_id", out_id, 2'd0);
        checkOutput("midrst_gnt", gnt, 4'b0000);

        // Saturation: one completion every 3 cycles, 260 completions in total.
        doReset();
        applyStimulus(1'b0, 4'b0001, 12'h000, 1'b1);
        repeat (762) stepCycle();
        checkOutput("sat_254", txn_cnt, 8'd254);
        repeat (3) stepCycle();
        checkOutput("sat_255", txn_cnt, 8'd255);
        repeat (15) stepCycle();
        checkOutput("sat_hold", txn_cnt, 8'd255);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
        $finish;
    end

endmodule

// File: doc/decode_scheduler.md
DECODE_SCHEDULER -- requirements
Module: decode_scheduler

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of requesters (power of 2, 2..8).
REQ-002 SHALL have parameter SELW, default 3, select width per requester; OUTW = 2**SELW.
REQ-003 SHALL have port clk, input, 1, all state updates on the falling edge.
REQ-004 SHALL have port rst, input, 1, reset: synchronous, active-high.
REQ-005 SHALL have port req, input, NREQ, per-requester request level.
REQ-006 SHALL have port sel, input, NREQ*SELW, packed selects; requester i occupies bits [i*SELW +: SELW].
REQ-007 SHALL have port gnt, output, NREQ, one-hot, one-cycle acceptance pulse.
REQ-008 SHALL have port out_valid, output, 1, result valid.
REQ-009 SHALL have port out_ready, input, 1, consumer accepts result.
REQ-010 SHALL have port out_data, output, OUTW, active-low one-hot decode result.
REQ-011 SHALL have port out_id, output, log2(NREQ), index of the requester owning out_data.
REQ-012 SHALL have port busy, output, 1, high whenever state is not IDLE.
REQ-013 SHALL have port txn_cnt, output, 8, saturating count of completed transactions.

Function
REQ-014 SHALL implement FSM states IDLE, DECODE and HOLD.
REQ-015 IDLE: with req nonzero, SHALL pick the first set bit at or after rr_ptr (cyclic), latch its sel and index, pulse gnt[winner] for exactly one cycle, and go to DECODE; with req zero, SHALL stay in IDLE.
REQ-016 DECODE: SHALL register out_data = all ones except bit latched_sel = 0, set out_valid = 1, drive out_id = winner, and go to HOLD.
REQ-017 HOLD: SHALL keep out_data, out_id and out_valid stable while out_ready = 0.
REQ-018 HOLD, on a clock edge with out_valid & out_ready: SHALL clear out_valid, set rr_ptr = winner+1 (mod NREQ, wraps NREQ-1 -> 0), increment txn_cnt (saturate at 255), and go to IDLE.
REQ-019 Minimum issue-to-issue spacing SHALL be 3 cycles; grant-to-out_valid latency SHALL be exactly 1 cycle.
REQ-020 out_ready asserted before out_valid SHALL have no effect; the transfer SHALL complete on the first cycle both are high.
REQ-021 req or sel changes after gnt SHALL NOT affect the in-flight result; a req deasserted before its grant SHALL be dropped silently.
REQ-022 gnt SHALL be zero in DECODE and HOLD regardless of req.
REQ-023 Any requester holding req high SHALL be granted within NREQ transactions (no starvation).
REQ-024 out_data SHALL be all ones whenever out_valid = 0.

Reset
REQ-025 On rst = 1 at a clock edge, SHALL set state = IDLE, rr_ptr = 0, gnt = 0, out_valid = 0, out_data = all ones, out_id = 0, txn_cnt = 0, and busy = 0, overriding any in-flight transaction (including HOLD).
REQ-026 While rst is high, SHALL issue no grant even if req is nonzero.

Structure
REQ-027 SHALL place the FSM state encoding and the NREQ/SELW defaults in a shared package, decode_sched_pkg.
REQ-028 SHALL isolate the registered active-low decode (enable, select in; OUTW result out; clears to all ones) as sub-module sel_decoder; arbitration and FSM SHALL stay in decode_scheduler.

Verification
REQ-029 Reset, then req=4'b0001 with sel0=3'd2 and out_ready=1: gnt=4'b0001 for 1 cycle; next cycle out_valid=1, out_data=8'hFB, out_id=0; txn_cnt=1 after the handshake.
REQ-030 req=4'b1111 held, out_ready=1, selects 0/1/2/3: grant order 0,1,2,3,0; out_data sequence FE, FD, FB, F7; each grant exactly 3 cycles apart.
REQ-031 Backpressure: out_ready=0 for 5 cycles in HOLD with sel=3'd7: out_data=8'h7F stable and busy=1 throughout, no gnt; then out_ready=1 -> one transfer, return to IDLE.
REQ-032 Wrap: rr_ptr=3 after a grant to 2; req=4'b1001 -> grant 3, then grant 0.
REQ-033 Reset mid-HOLD with out_valid=1: next cycle out_valid=0, out_data=8'hFF, txn_cnt=0, state IDLE; no completion counted.
REQ-034 Saturation: 260 completed transactions -> txn_cnt=255.
